// File: rtl/shift_arbiter_pkg.sv
// Shared types for the shift arbiter: shift opcodes, output-stage states
// and the number of requesters.
package shift_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_op_t;

  // Output register occupancy; res_valid is simply (state == OUT_FULL).
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Bundle of the two request channels and the result channel.
//
// Handshake rule for every channel: a transfer happens at a rising edge
// where valid && ready are both 1. The sender holds valid and its payload
// stable until that edge; ready may be computed combinationally from the
// valids and res_ready but never from the payload being offered.
interface shift_arbiter_if #(
  parameter int N = 2
);
  localparam int W = 2 ** N;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [N-1:0] req0_shamt;
  logic [1:0]   req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [N-1:0] req1_shamt;
  logic [1:0]   req1_op;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_y;
  logic         res_id;

  // Requesters and the result consumer.
  modport master (
    output req0_valid, req0_a, req0_shamt, req0_op,
    output req1_valid, req1_a, req1_shamt, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_y, res_id
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_a, req0_shamt, req0_op,
    input  req1_valid, req1_a, req1_shamt, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_y, res_id
  );

endinterface

// File: rtl/shift_arbiter_shift_unit.sv
// Combinational W-bit shifter: logical left/right, arithmetic right and
// rotate left. A zero shift amount passes the operand through unchanged.
module shift_unit
  import shift_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [2**N-1:0] a,
  input  logic [N-1:0]    shamt,
  input  shift_op_t       op,
  output logic [2**N-1:0] y
);
  localparam int W = 2 ** N;

  logic [2*W-1:0] rot_tmp;

  // Rotate is the upper half of a doubled operand shifted left.
  assign rot_tmp = {a, a} << shamt;

  // Select the shift variant.
  always_comb begin
    y = a;
    case (op)
      SLL: y = a << shamt;
      SRL: y = a >> shamt;
      SRA: y = W'($signed(a) >>> shamt);
      ROL: y = rot_tmp[2*W-1:W];
      default: y = a;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared shift unit with a
// single-entry registered result stage tagged with the requester id.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_arbiter_if.slave   bus,
  output out_state_t       state_dbg
);
  localparam int W = 2 ** N;

  out_state_t   state_q, state_d;
  logic         last_grant_q;
  logic         accept;
  logic         grant_valid;
  logic         grant_idx;
  logic         fire;
  logic [W-1:0] sel_a;
  logic [N-1:0] sel_shamt;
  logic [1:0]   sel_op;
  logic [W-1:0] shift_y;
  logic [W-1:0] res_y_q;
  logic         res_id_q;

  // The output register can take a new result when empty or being drained.
  assign accept = (state_q == OUT_EMPTY) || bus.res_ready;

  // Round-robin choice: on contention the requester not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    case ({bus.req1_valid, bus.req0_valid})
      2'b01: begin grant_valid = 1'b1; grant_idx = 1'b0;          end
      2'b10: begin grant_valid = 1'b1; grant_idx = 1'b1;          end
      2'b11: begin grant_valid = 1'b1; grant_idx = ~last_grant_q; end
      default: ;
    endcase
  end

  // Readies are held low during reset so nothing is lost in that cycle.
  assign fire           = rst_n && accept && grant_valid;
  assign bus.req0_ready = fire && !grant_idx;
  assign bus.req1_ready = fire && grant_idx;

  // Route the granted payload into the single shared shifter.
  always_comb begin
    sel_a     = bus.req0_a;
    sel_shamt = bus.req0_shamt;
    sel_op    = bus.req0_op;
    if (grant_idx) begin
      sel_a     = bus.req1_a;
      sel_shamt = bus.req1_shamt;
      sel_op    = bus.req1_op;
    end
  end

  shift_unit #(.N(N)) u_shift (
    .a     (sel_a),
    .shamt (sel_shamt),
    .op    (shift_op_t'(sel_op)),
    .y     (shift_y)
  );

  // Output-stage state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= OUT_EMPTY;
    else        state_q <= state_d;
  end

  // Fill on a grant, empty on a drain with no grant, hold under backpressure.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = grant_valid ? OUT_FULL : OUT_EMPTY;
  end

  // Result payload and round-robin pointer; stale payload is kept on drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_y_q      <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (fire) begin
      res_y_q      <= shift_y;
      res_id_q     <= grant_idx;
      last_grant_q <= grant_idx;
    end
  end

  assign bus.res_valid = (state_q == OUT_FULL);
  assign bus.res_y     = res_y_q;
  assign bus.res_id    = res_id_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios followed by constrained
// random traffic, all compared against an arithmetic reference model.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  localparam int N = 2;
  localparam int W = 2 ** N;

  logic       clk;
  logic       rst_n;
  out_state_t state_dbg;

  shift_arbiter_if #(.N(N)) bus ();

  shift_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];  // {id, y} of every accepted request, in order

  // Reference model state (what the outputs should show).
  logic         m_valid;
  logic [W-1:0] m_y;
  logic         m_id;
  logic         m_last;
  // Last cycle's expected handshakes, used by drivers to hold payloads.
  logic         e_rdy0, e_rdy1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Shift computed with integer arithmetic on values 0..2**W-1.
  function automatic logic [W-1:0] ref_shift(input int a, input int s, input int op);
    int m, p, sa, r;
    logic [31:0] rv;
    m = 1 << W;
    p = 1 << s;
    r = a;
    case (op)
      0: r = (a * p) % m;
      1: r = a / p;
      2: begin
        sa = (a >= m / 2) ? a - m : a;
        r  = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        r  = (r + m) % m;
      end
      default: r = ((a * p) % m) + (a * p) / m;
    endcase
    rv = r;
    return rv[W-1:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_req(input int idx, input logic v, input logic [W-1:0] a,
                           input logic [N-1:0] s, input logic [1:0] op);
    if (idx == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_shamt = s; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_shamt = s; bus.req1_op = op;
    end
  endtask

  // One clock: check readies against the model, advance the model, then
  // check the registered outputs. Entered and left just after a negedge.
  task automatic cycle();
    logic acc, gv, gi;
    logic [W:0] front;
    #1;
    acc = !m_valid || bus.res_ready;
    gv  = bus.req0_valid || bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) gi = !m_last;
    else                                  gi = bus.req1_valid;
    e_rdy0 = rst_n && acc && gv && !gi;
    e_rdy1 = rst_n && acc && gv && gi;
    chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e_rdy0});
    chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e_rdy1});

    if (!rst_n) begin
      m_valid = 1'b0; m_y = '0; m_id = 1'b0; m_last = 1'b1;
      exp_q.delete();
    end else begin
      if (m_valid && bus.res_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          front = exp_q.pop_front();
          chk("sb_result", {27'd0, bus.res_id, bus.res_y}, {27'd0, front});
        end
      end
      if (e_rdy0 || e_rdy1) begin
        m_y = gi ? ref_shift(int'(bus.req1_a), int'(bus.req1_shamt), int'(bus.req1_op))
                 : ref_shift(int'(bus.req0_a), int'(bus.req0_shamt), int'(bus.req0_op));
        m_id    = gi;
        m_last  = gi;
        m_valid = 1'b1;
        exp_q.push_back({m_id, m_y});
      end else if (acc) begin
        m_valid = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    chk("res_valid", {31'd0, bus.res_valid}, {31'd0, m_valid});
    chk("state_dbg", {31'd0, state_dbg == OUT_FULL}, {31'd0, m_valid});
    chk("res_y", {28'd0, bus.res_y}, {28'd0, m_y});
    chk("res_id", {31'd0, bus.res_id}, {31'd0, m_id});
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic idle_reqs();
    drive_req(0, 1'b0, '0, '0, 2'b00);
    drive_req(1, 1'b0, '0, '0, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [W-1:0] sweep_exp [4];
    logic [W-1:0] ra;
    logic [N-1:0] rs;
    logic [1:0]   ro;
    logic         hold0, hold1;

    sweep_exp[0] = 4'b0100;
    sweep_exp[1] = 4'b0010;
    sweep_exp[2] = 4'b1110;
    sweep_exp[3] = 4'b0110;

    m_valid = 1'b0; m_y = '0; m_id = 1'b0; m_last = 1'b1;
    e_rdy0 = 1'b0; e_rdy1 = 1'b0;
    rst_n = 1'b0;
    bus.res_ready = 1'b0;
    idle_reqs();
    @(negedge clk);
    apply_reset();
    chk("rst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_y", {28'd0, bus.res_y}, 32'd0);
    chk("rst_id", {31'd0, bus.res_id}, 32'd0);

    // Single request.
    bus.res_ready = 1'b1;
    drive_req(0, 1'b1, 4'b1011, 2'd1, 2'b00);
    cycle();
    chk("single_y", {28'd0, bus.res_y}, 32'b0110);
    chk("single_id", {31'd0, bus.res_id}, 32'd0);
    chk("single_valid", {31'd0, bus.res_valid}, 32'd1);

    // Opcode sweep, shamt=2 then shamt=0.
    for (int op = 0; op < 4; op++) begin
      drive_req(0, 1'b1, 4'b1001, 2'd2, op[1:0]);
      cycle();
      chk("sweep_s2", {28'd0, bus.res_y}, {28'd0, sweep_exp[op]});
      drive_req(0, 1'b1, 4'b1001, 2'd0, op[1:0]);
      cycle();
      chk("sweep_s0", {28'd0, bus.res_y}, 32'b1001);
    end
    idle_reqs();
    cycle();

    // Contention after reset: 0,1,0,1 with no idle cycle.
    apply_reset();
    bus.res_ready = 1'b1;
    drive_req(0, 1'b1, 4'b0011, 2'd1, 2'b00);
    drive_req(1, 1'b1, 4'b1100, 2'd1, 2'b01);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("contend_id", {31'd0, bus.res_id}, i % 2);
      chk("contend_valid", {31'd0, bus.res_valid}, 32'd1);
    end

    // Backpressure with both requesters waiting, then release.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    bus.res_ready = 1'b1;
    cycle();
    chk("bp_release_id", {31'd0, bus.res_id}, 32'd0);

    // Drain.
    idle_reqs();
    cycle();
    chk("drain_valid", {31'd0, bus.res_valid}, 32'd0);

    // Reset while holding a result under backpressure.
    drive_req(1, 1'b1, 4'b0101, 2'd3, 2'b11);
    cycle();
    idle_reqs();
    bus.res_ready = 1'b0;
    apply_reset();
    chk("mid_rst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("mid_rst_y", {28'd0, bus.res_y}, 32'd0);
    bus.res_ready = 1'b1;
    drive_req(0, 1'b1, 4'b1000, 2'd3, 2'b10);
    drive_req(1, 1'b1, 4'b0001, 2'd1, 2'b00);
    cycle();
    chk("mid_rst_first", {31'd0, bus.res_id}, 32'd0);
    chk("mid_rst_sra", {28'd0, bus.res_y}, 32'b1111);
    idle_reqs();
    cycle();

    // Random traffic; payloads held until accepted.
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold0) begin
        ra = W'($urandom_range(0, 2**W - 1));
        rs = N'($urandom_range(0, W - 1));
        ro = 2'($urandom_range(0, 3));
        drive_req(0, $urandom_range(0, 99) < 60, ra, rs, ro);
      end
      if (!hold1) begin
        ra = W'($urandom_range(0, 2**W - 1));
        rs = N'($urandom_range(0, W - 1));
        ro = 2'($urandom_range(0, 3));
        drive_req(1, $urandom_range(0, 99) < 60, ra, rs, ro);
      end
      bus.res_ready = $urandom_range(0, 99) < 70;
      if (i == 200) rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      hold0 = bus.req0_valid && !e_rdy0;
      hold1 = bus.req1_valid && !e_rdy1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
